// File: rtl/bpu_tagged_dual.sv
// Dual-update branch prediction unit: saturating-counter PHT plus tagged BTB, three combinational lookups.
// Optional gshare indexing of the PHT is enabled by defining BPU_GSHARE_EN.
module bpu_tagged_dual #(
  parameter int PC_W   = 11,
  parameter int IDX_W  = 5,
  parameter int TAG_W  = 4,
  parameter int CTR_W  = 2,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   lk_pc0,
  input  logic [PC_W-1:0]   lk_pc1,
  input  logic [PC_W-1:0]   lk_fpc,
  output logic              lk_taken0,
  output logic              lk_taken1,
  output logic              lk_ftaken,
  output logic [PC_W-1:0]   lk_tgt0,
  output logic [PC_W-1:0]   lk_tgt1,
  output logic [PC_W-1:0]   lk_ftgt,
  input  logic              up_v0,
  input  logic              up_v1,
  input  logic [PC_W-1:0]   up_pc0,
  input  logic [PC_W-1:0]   up_pc1,
  input  logic [PC_W-1:0]   up_tgt0,
  input  logic [PC_W-1:0]   up_tgt1,
  input  logic              up_taken0,
  input  logic              up_taken1,
  input  logic              up_pred0,
  input  logic              up_pred1,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] br_cnt,
  output logic [STAT_W-1:0] mp_cnt
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int SW1   = STAT_W + 1;
  localparam logic [CTR_W-1:0]  CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0]  PHT_INIT = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [STAT_W:0]   STAT_MAX = {1'b0, {STAT_W{1'b1}}};

  logic [CTR_W-1:0]  pht_r         [DEPTH];
  logic [CTR_W-1:0]  pht_nxt_s     [DEPTH];
  logic [DEPTH-1:0]  btb_v_r;
  logic [DEPTH-1:0]  btb_v_nxt_s;
  logic [TAG_W-1:0]  btb_tag_r     [DEPTH];
  logic [TAG_W-1:0]  btb_tag_nxt_s [DEPTH];
  logic [PC_W-1:0]   btb_tgt_r     [DEPTH];
  logic [PC_W-1:0]   btb_tgt_nxt_s [DEPTH];
  logic [STAT_W-1:0] br_cnt_r;
  logic [STAT_W-1:0] mp_cnt_r;
  logic [STAT_W:0]   br_sum_s;
  logic [STAT_W:0]   mp_sum_s;
  logic [IDX_W-1:0]  up_pidx0_s;
  logic [IDX_W-1:0]  up_pidx1_s;
  logic [PC_W-1:0]   lk_pc_s       [3];
  logic              lk_taken_s    [3];
  logic [PC_W-1:0]   lk_tgt_s      [3];
  logic              unused_s;

  function automatic logic [CTR_W-1:0] ctr_next(input logic [CTR_W-1:0] c, input logic t);
    if (t) begin
      return (c == CTR_MAX) ? c : c + CTR_W'(1);
    end else begin
      return (c == {CTR_W{1'b0}}) ? c : c - CTR_W'(1);
    end
  endfunction

`ifdef BPU_GSHARE_EN
  logic [IDX_W-1:0] ghr_r;
  logic [IDX_W-1:0] ghr_nxt_s;

  // PHT index folds in global history; BTB index stays the raw PC bits.
  function automatic logic [IDX_W-1:0] pht_idx(input logic [PC_W-1:0] pc);
    return pc[IDX_W-1:0] ^ ghr_r;
  endfunction

  // History shifts once per valid lane, lane 0 being older.
  always_comb begin
    ghr_nxt_s = ghr_r;
    if (up_v0) begin
      ghr_nxt_s = {ghr_nxt_s[IDX_W-2:0], up_taken0};
    end else begin
      ghr_nxt_s = ghr_nxt_s;
    end
    if (up_v1) begin
      ghr_nxt_s = {ghr_nxt_s[IDX_W-2:0], up_taken1};
    end else begin
      ghr_nxt_s = ghr_nxt_s;
    end
  end

  // Global history register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ghr_r <= {IDX_W{1'b0}};
    end else begin
      ghr_r <= ghr_nxt_s;
    end
  end
`else
  function automatic logic [IDX_W-1:0] pht_idx(input logic [PC_W-1:0] pc);
    return pc[IDX_W-1:0];
  endfunction
`endif

  assign up_pidx0_s = pht_idx(up_pc0);
  assign up_pidx1_s = pht_idx(up_pc1);
  assign unused_s   = ^{up_pc0, up_pc1};

  assign lk_pc_s[0] = lk_pc0;
  assign lk_pc_s[1] = lk_pc1;
  assign lk_pc_s[2] = lk_fpc;

  // Three independent lookups against the current table state.
  always_comb begin
    logic [IDX_W-1:0] bidx;
    logic             hit;
    bidx = {IDX_W{1'b0}};
    hit  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bidx          = lk_pc_s[k][IDX_W-1:0];
      hit           = btb_v_r[bidx] && (btb_tag_r[bidx] == lk_pc_s[k][IDX_W +: TAG_W]);
      lk_taken_s[k] = hit & pht_r[pht_idx(lk_pc_s[k])][CTR_W-1];
      lk_tgt_s[k]   = hit ? btb_tgt_r[bidx] : lk_pc_s[k] + PC_W'(1);
    end
  end

  assign lk_taken0 = lk_taken_s[0];
  assign lk_taken1 = lk_taken_s[1];
  assign lk_ftaken = lk_taken_s[2];
  assign lk_tgt0   = lk_tgt_s[0];
  assign lk_tgt1   = lk_tgt_s[1];
  assign lk_ftgt   = lk_tgt_s[2];

  // Lane 0 applied first, then lane 1 on top, so same-index updates compose and lane 1 wins the BTB.
  always_comb begin
    pht_nxt_s     = pht_r;
    btb_v_nxt_s   = btb_v_r;
    btb_tag_nxt_s = btb_tag_r;
    btb_tgt_nxt_s = btb_tgt_r;
    if (up_v0) begin
      pht_nxt_s[up_pidx0_s] = ctr_next(pht_nxt_s[up_pidx0_s], up_taken0);
      if (up_taken0) begin
        btb_v_nxt_s[up_pc0[IDX_W-1:0]]   = 1'b1;
        btb_tag_nxt_s[up_pc0[IDX_W-1:0]] = up_pc0[IDX_W +: TAG_W];
        btb_tgt_nxt_s[up_pc0[IDX_W-1:0]] = up_tgt0;
      end else begin
        btb_v_nxt_s = btb_v_nxt_s;
      end
    end else begin
      btb_v_nxt_s = btb_v_nxt_s;
    end
    if (up_v1) begin
      pht_nxt_s[up_pidx1_s] = ctr_next(pht_nxt_s[up_pidx1_s], up_taken1);
      if (up_taken1) begin
        btb_v_nxt_s[up_pc1[IDX_W-1:0]]   = 1'b1;
        btb_tag_nxt_s[up_pc1[IDX_W-1:0]] = up_pc1[IDX_W +: TAG_W];
        btb_tgt_nxt_s[up_pc1[IDX_W-1:0]] = up_tgt1;
      end else begin
        btb_v_nxt_s = btb_v_nxt_s;
      end
    end else begin
      btb_v_nxt_s = btb_v_nxt_s;
    end
  end

  // Table state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btb_v_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        pht_r[i]     <= PHT_INIT;
        btb_tag_r[i] <= {TAG_W{1'b0}};
        btb_tgt_r[i] <= {PC_W{1'b0}};
      end
    end else begin
      btb_v_r   <= btb_v_nxt_s;
      pht_r     <= pht_nxt_s;
      btb_tag_r <= btb_tag_nxt_s;
      btb_tgt_r <= btb_tgt_nxt_s;
    end
  end

  assign br_sum_s = {1'b0, br_cnt_r} + SW1'(up_v0) + SW1'(up_v1);
  assign mp_sum_s = {1'b0, mp_cnt_r} + SW1'(up_v0 & (up_pred0 != up_taken0))
                                     + SW1'(up_v1 & (up_pred1 != up_taken1));

  // Saturating statistics; clear wins over same-cycle increments.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      br_cnt_r <= {STAT_W{1'b0}};
      mp_cnt_r <= {STAT_W{1'b0}};
    end else if (stat_clr) begin
      br_cnt_r <= {STAT_W{1'b0}};
      mp_cnt_r <= {STAT_W{1'b0}};
    end else begin
      br_cnt_r <= (br_sum_s > STAT_MAX) ? STAT_MAX[STAT_W-1:0] : br_sum_s[STAT_W-1:0];
      mp_cnt_r <= (mp_sum_s > STAT_MAX) ? STAT_MAX[STAT_W-1:0] : mp_sum_s[STAT_W-1:0];
    end
  end

  assign br_cnt = br_cnt_r;
  assign mp_cnt = mp_cnt_r;

endmodule
